// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// No logic and no latency: types, encodings and default constants only.
// No backpressure: the package holds no state.
package instr_fetch_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

  // Default first fetch address and the no-op driven during bubbles
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_2000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // One fetched instruction together with the address it came from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Sequential word address; wraps naturally at the top of the 32-bit space
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  // Force an address onto a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO with push/pop/clear and an occupancy count.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: none internally; the owner keeps count below 2 before pushing.
module fetch_fifo #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Ignore pops on empty and pushes on full so the pointers never corrupt
  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count != 2'd2) || do_pop);
  end

  // Pointer, count and storage update; clear wins over any push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues word fetches, tracks in-flight PCs, feeds decode.
// Latency: response to decode output in 1 cycle when the buffer is empty.
// Backpressure: stall freezes outputs; at most 2 fetches in flight or buffered.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        bubble
);

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic [31:0]  fetch_pc;
  logic [1:0]   stale_cnt;
  logic [1:0]   stale_on_redirect;
  logic [2:0]   outstanding;
  logic [2:0]   occupancy;

  logic [1:0]   infl_cnt;
  logic [31:0]  infl_head;
  logic [1:0]   buf_cnt;
  logic [63:0]  buf_head_raw;
  fetch_entry_t buf_head;
  fetch_entry_t resp_entry;

  logic         req_fire;
  logic         resp_stale;
  logic         resp_accept;
  logic         out_ready;
  logic         bypass;
  logic         buf_push;
  logic         buf_pop;
  logic         unused_addr_bits;

  // The low address bits of a redirect target carry no meaning
  assign unused_addr_bits = ^redirect_pc[1:0];

  // Handshake and routing decisions for this cycle
  always_comb begin
    out_ready   = !redirect && !stall;
    req_fire    = imem_req_valid && imem_req_ready;
    resp_stale  = imem_resp_valid && (stale_cnt != 2'd0);
    resp_accept = imem_resp_valid && (state == ST_FETCH) && (stale_cnt == 2'd0)
                  && !redirect && (infl_cnt != 2'd0);
    bypass      = resp_accept && out_ready && (buf_cnt == 2'd0);
    buf_push    = resp_accept && !bypass;
    buf_pop     = out_ready && (buf_cnt != 2'd0);
    occupancy   = {1'b0, infl_cnt} + {1'b0, buf_cnt};
    buf_head    = fetch_entry_t'(buf_head_raw);
    resp_entry  = '{pc: infl_head, instr: imem_resp_data};
  end

  // Responses still owed by memory that a redirect turns stale; one arriving
  // in the same cycle as the redirect is already accounted for
  always_comb begin
    outstanding = {1'b0, infl_cnt} + {1'b0, stale_cnt};
    if (imem_resp_valid && (outstanding != 3'd0)) begin
      outstanding = outstanding - 3'd1;
    end
    stale_on_redirect = outstanding[1:0];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: flush only while stale responses remain outstanding
  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect && (stale_on_redirect != 2'd0)) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (redirect) begin
          state_nxt = (stale_on_redirect != 2'd0) ? ST_FLUSH : ST_FETCH;
        end else if ((stale_cnt == 2'd0) ||
                     ((stale_cnt == 2'd1) && imem_resp_valid)) begin
          state_nxt = ST_FETCH;
        end
      end
      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

  // FSM outputs: request only when fetching, not redirecting, and with room
  always_comb begin
    imem_req_valid = (state == ST_FETCH) && !redirect && (occupancy < 3'd2);
    imem_req_addr  = fetch_pc;
  end

  // Fetch address: redirect retargets, an accepted request advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= word_align(redirect_pc);
    end else if (req_fire) begin
      fetch_pc <= next_word(fetch_pc);
    end
  end

  // Stale response counter: reloaded on redirect, drained by discarded responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stale_cnt <= 2'd0;
    end else if (redirect) begin
      stale_cnt <= stale_on_redirect;
    end else if (resp_stale) begin
      stale_cnt <= stale_cnt - 2'd1;
    end
  end

  // Decode-facing register: redirect inserts a bubble, stall holds, otherwise
  // take the buffer head, else a response passing straight through, else a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr  <= NOP_INSTR;
      pc     <= RESET_PC;
      bubble <= 1'b1;
    end else if (redirect) begin
      instr  <= NOP_INSTR;
      bubble <= 1'b1;
    end else if (!stall) begin
      if (buf_cnt != 2'd0) begin
        instr  <= buf_head.instr;
        pc     <= buf_head.pc;
        bubble <= 1'b0;
      end else if (bypass) begin
        instr  <= resp_entry.instr;
        pc     <= resp_entry.pc;
        bubble <= 1'b0;
      end else begin
        instr  <= NOP_INSTR;
        bubble <= 1'b1;
      end
    end
  end

  // Addresses of requests accepted by memory but not yet answered
  fetch_fifo #(.WIDTH(32)) u_inflight (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (resp_accept),
    .clear     (redirect),
    .head      (infl_head),
    .count     (infl_cnt)
  );

  // Returned instructions waiting for decode to take them
  fetch_fifo #(.WIDTH(64)) u_resp_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_data (resp_entry),
    .pop       (buf_pop),
    .clear     (redirect),
    .head      (buf_head_raw),
    .count     (buf_cnt)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: per-cycle vector table plus an in-order scoreboard.
// Memory model answers each accepted fetch one cycle later unless held.
// Scoreboard entries are queued at request acceptance and popped on new output.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        bubble;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr           (instr),
    .pc              (pc),
    .bubble          (bubble)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rdr;
    logic [31:0] rpc;
    logic        rdy;
    logic        hold;
    logic        mflush;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_bub;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] mq[$];
  logic [63:0] exp_q[$];
  int          compared   = 0;
  int          mismatched = 0;

  logic        acc;
  logic [31:0] acc_addr;
  logic        fired;
  logic        last_ok;

  function automatic void add(input logic rst, stl, rdr, input logic [31:0] rpc,
                              input logic rdy, hold, mflush, exp_rv,
                              input logic [31:0] exp_addr, input logic exp_bub,
                              input logic [31:0] exp_pc);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.rdy = rdy;
    v.hold = hold; v.mflush = mflush; v.exp_rv = exp_rv; v.exp_addr = exp_addr;
    v.exp_bub = exp_bub; v.exp_pc = exp_pc;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s row %0d: got %h, expected %h", name, row, act, expv);
    end
  endtask

  initial begin
    //  rst stl rdr rpc           rdy hld mfl | rv  addr          bub pc
    add(0, 0, 0, 32'h0,         1, 0, 0,   0, 32'h0,         1, 32'h2000);     // in reset
    add(1, 0, 0, 32'h0,         1, 0, 0,   0, 32'h0,         1, 32'h2000);     // BOOT
    add(1, 0, 0, 32'h0,         1, 0, 0,   1, 32'h2000,      1, 32'h2000);
    add(1, 0, 0, 32'h0,         1, 0, 0,   1, 32'h2004,      1, 32'h2000);
    add(1, 0, 0, 32'h0,         1, 0, 0,   1, 32'h2008,      0, 32'h2000);
    add(1, 1, 0, 32'h0,         1, 0, 0,   1, 32'h200C,      0, 32'h2004);     // stall x3
    add(1, 1, 0, 32'h0,         1, 0, 0,   0, 32'h0,         0, 32'h2004);
    add(1, 1, 0, 32'h0,         1, 0, 0,   0, 32'h0,         0, 32'h2004);
    add(1, 0, 0, 32'h0,         1, 0, 0,   0, 32'h0,         0, 32'h2004);
    add(1, 0, 0, 32'h0,         1, 0, 0,   1, 32'h2010,      0, 32'h2008);
    add(1, 0, 0, 32'h0,         1, 0, 0,   1, 32'h2014,      0, 32'h200C);
    add(1, 0, 0, 32'h0,         1, 1, 0,   1, 32'h2018,      0, 32'h2010);     // memory holds
    add(1, 0, 1, 32'h3002,      1, 1, 0,   0, 32'h0,         1, 32'h2010);     // redirect, 2 in flight
    add(1, 0, 0, 32'h0,         1, 0, 0,   0, 32'h0,         1, 32'h2010);
    add(1, 0, 0, 32'h0,         1, 0, 0,   0, 32'h0,         1, 32'h2010);
    add(1, 0, 0, 32'h0,         1, 0, 0,   1, 32'h3000,      1, 32'h2010);
    add(1, 0, 0, 32'h0,         1, 0, 0,   1, 32'h3004,      1, 32'h2010);
    add(1, 1, 1, 32'hFFFF_FFFC, 1, 0, 0,   0, 32'h0,         0, 32'h3000);     // redirect+stall+resp
    add(1, 0, 0, 32'h0,         1, 0, 0,   1, 32'hFFFF_FFFC, 1, 32'h3000);
    add(1, 0, 0, 32'h0,         1, 0, 0,   1, 32'h0000_0000, 1, 32'h3000);     // wrap
    add(1, 0, 0, 32'h0,         1, 0, 0,   1, 32'h4,         0, 32'hFFFF_FFFC);
    add(1, 0, 0, 32'h0,         1, 0, 0,   1, 32'h8,         0, 32'h0);
    add(1, 0, 0, 32'h0,         1, 1, 0,   1, 32'hC,         0, 32'h4);
    add(0, 0, 0, 32'h0,         1, 0, 1,   0, 32'h0,         1, 32'h2000);     // reset mid-flight
    add(0, 0, 0, 32'h0,         1, 0, 0,   0, 32'h0,         1, 32'h2000);
    add(1, 0, 0, 32'h0,         1, 0, 0,   0, 32'h0,         1, 32'h2000);     // BOOT, late response
    add(1, 0, 0, 32'h0,         1, 0, 0,   1, 32'h2000,      1, 32'h2000);
    add(1, 0, 0, 32'h0,         1, 0, 0,   1, 32'h2004,      1, 32'h2000);
    add(1, 0, 0, 32'h0,         1, 0, 0,   1, 32'h2008,      0, 32'h2000);
    add(1, 0, 0, 32'h0,         0, 0, 0,   1, 32'h200C,      0, 32'h2004);     // not ready
    add(1, 0, 0, 32'h0,         1, 0, 0,   1, 32'h200C,      0, 32'h2008);
    add(1, 0, 0, 32'h0,         1, 0, 0,   1, 32'h2010,      1, 32'h2008);
    add(1, 0, 0, 32'h0,         1, 0, 0,   1, 32'h2014,      0, 32'h200C);
    add(1, 0, 0, 32'h0,         1, 0, 0,   1, 32'h2018,      0, 32'h2010);

    rst_n = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    acc = 1'b0; acc_addr = 32'h0; fired = 1'b0; last_ok = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      rst_n          = v.rst;
      stall          = v.stl;
      redirect       = v.rdr;
      redirect_pc    = v.rpc;
      imem_req_ready = v.rdy;

      // memory model: retire the response taken at the last edge, queue new fetch
      if (fired) void'(mq.pop_front());
      if (acc) mq.push_back(acc_addr);
      if (v.mflush) begin
        mq.delete();
        mq.push_back(32'h0000_5550);
        mq.push_back(32'h0000_5554);
        mq.push_back(32'h0000_5558);
      end
      imem_resp_valid = !v.hold && (mq.size() > 0);
      imem_resp_data  = imem_resp_valid ? ~mq[0] : 32'h0;

      @(negedge clk);

      chk("req_valid", i, {31'b0, imem_req_valid}, {31'b0, v.exp_rv});
      if (v.exp_rv) chk("req_addr", i, imem_req_addr, v.exp_addr);
      chk("bubble", i, {31'b0, bubble}, {31'b0, v.exp_bub});
      chk("pc", i, pc, v.exp_pc);
      if (v.exp_bub) chk("nop_instr", i, instr, NOP);

      // scoreboard: a fresh valid output must match the oldest live fetch
      if (last_ok && bubble === 1'b0) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL sb_unexpected row %0d: got pc %h, expected no output", i, pc);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("sb_pc", i, pc, e[63:32]);
          chk("sb_instr", i, instr, e[31:0]);
        end
      end

      acc      = imem_req_valid && imem_req_ready && rst_n;
      acc_addr = imem_req_addr;
      fired    = imem_resp_valid;
      if (acc) exp_q.push_back({imem_req_addr, ~imem_req_addr});
      if (redirect || !rst_n) exp_q.delete();
      last_ok  = rst_n && !stall && !redirect;

      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_2000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013, instruction driven while bubble=1.
REQ-003 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port stall  input  1  downstream decode/read stage holds; instr/pc/bubble SHALL hold.
REQ-006 Port redirect  input  1  taken branch/jump from execute; flush and refetch.
REQ-007 Port redirect_pc  input  32  new fetch target; bits [1:0] ignored, treated as 0.
REQ-008 Port imem_req_valid  output  1  fetch request to instruction memory.
REQ-009 Port imem_req_ready  input  1  memory accepts request when valid&&ready.
REQ-010 Port imem_req_addr  output  32  word-aligned fetch address.
REQ-011 Port imem_resp_valid  input  1  in-order response strobe, at least 1 cycle after acceptance.
REQ-012 Port imem_resp_data  input  32  fetched instruction word.
REQ-013 Port instr  output  32  registered instruction to decode/read stage.
REQ-014 Port pc  output  32  registered address of instr.
REQ-015 Port bubble  output  1  1 = instr/pc invalid; decode/read stage inserts no-op.

Function
REQ-016 FSM states BOOT, FETCH, FLUSH; BOOT->FETCH unconditionally one cycle after reset release.
REQ-017 FETCH->FLUSH on redirect when stale count (REQ-023) would be nonzero; FLUSH->FETCH when stale count reaches 0; redirect in FLUSH stays in FLUSH and recomputes stale count.
REQ-018 imem_req_valid=1 only in FETCH, redirect=0, and (in-flight + buffer occupancy) < 2; imem_req_addr = fetch_pc.
REQ-019 On request acceptance fetch_pc += 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0), fetch_pc pushed into a 2-entry in-flight PC queue.
REQ-020 Non-stale response: pop in-flight PC queue, push {pc, data} into 2-entry response buffer; buffer never overflows by REQ-018.
REQ-021 Output register update when stall=0 and redirect=0: buffer non-empty -> load head, pop, bubble=0; buffer empty -> instr=NOP_INSTR, bubble=1, pc unchanged.
REQ-022 Response arriving with stall=0 and empty buffer SHALL pass to outputs the next cycle (1-cycle response-to-decode latency); stall=1 holds outputs, buffers response.
REQ-023 On redirect (overrides stall): next cycle bubble=1, instr=NOP_INSTR; buffer and in-flight queue cleared; fetch_pc=redirect_pc; stale count = in-flight count minus 1 if imem_resp_valid same cycle, else in-flight count; same-cycle response discarded.
REQ-024 Response while stale count > 0: discarded, stale count decremented, nothing pushed.
REQ-025 Redirect and stall both high: redirect wins; stall never blocks a flush.
REQ-026 Back-to-back redirects: each later redirect fully replaces target and recomputes stale count.
REQ-027 Sustained throughput with imem_req_ready=1, 1-cycle memory, stall=0: one valid instr per cycle.

Reset
REQ-028 rst_n=0 asynchronously: state=BOOT, fetch_pc=RESET_PC, pc=RESET_PC, instr=NOP_INSTR, bubble=1, imem_req_valid=0, buffers empty, stale count 0.
REQ-029 Reset mid-transaction abandons outstanding requests; responses arriving in BOOT SHALL be discarded.

Structure
REQ-030 Shared package holds FSM state encoding, NOP_INSTR value, RESET_PC default.
REQ-031 One sub-module fetch_fifo (2-entry, 64-bit {pc,instr}, push/pop/clear/count) instantiated for the response buffer; in-flight PC queue may reuse it at 32-bit width.

Verification
REQ-032 Reset release, ready=1, 1-cycle memory -> first request addr 32'h2000 one cycle after BOOT; pc 2000,2004,2008 with bubble=0 consecutive cycles.
REQ-033 stall=1 three cycles mid-stream -> instr/pc frozen at 32'h2004; no request issued once occupancy=2; resume yields 2008 next, no loss/duplication.
REQ-034 Two requests in flight, redirect to 32'h0000_3002 -> next request addr 32'h3000; both stale responses dropped; first valid pc 32'h3000.
REQ-035 redirect coincident with imem_resp_valid and stall=1 -> response discarded, bubble=1 next cycle, stale count = in-flight-1.
REQ-036 redirect_pc=32'hFFFF_FFFC -> fetch addresses FFFF_FFFC then 0000_0000.
REQ-037 rst_n low with 2 requests outstanding, late responses in BOOT -> discarded; outputs equal reset values.
